priority_encoder: RTL and testbench
===================================

# priority_encoder

Registered 8-to-3 priority encoder. Each clock it samples an 8-bit request vector and reports the index of the highest-numbered asserted bit, plus a `valid` flag that indicates at least one bit was set. It is a leaf block and serves as a generic arbitration/index helper wherever a one-of-N request must be reduced to a binary index.

## Interface

Parameters:
- `IN_W`, default 8: request vector width; must be ≥ 2.
- `OUT_W`, default 3: index width; equals ceil(log2(`IN_W`)); 3 at the default.

Ports:
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `in`, input, `IN_W` bits: request vector; bit i set means request i is active.
- `out`, output, `OUT_W` bits: registered index of the highest set bit of `in`.
- `valid`, output, 1 bit: registered; 1 when the sampled `in` had at least one bit set.

## Operation

- Priority is fixed: the MSB wins.
  - `out` = largest i such that `in[i]` = 1.
  - Lower-numbered set bits are ignored.
- Next-state logic is combinational over `in`:
  - Scan from bit `IN_W-1` down to bit 0.
  - The first 1 found gives the index.
  - `valid_next` = OR-reduction of `in`.
- All-zero input: `out_next` = 0 and `valid_next` = 0. Consumers must qualify `out` with `valid`, because `out` = 0 is also the legitimate index for `in` = 8'b0000_0001.
- No X propagation from unused index codes. When `IN_W` < 2^`OUT_W`, codes ≥ `IN_W` never appear on `out`.
- There is no enable input. The input is sampled every cycle, and there is no handshake or backpressure.
- Reset values:
  - `out` = 0.
  - `valid` = 0.

## Timing

- Latency is one cycle. `in` is sampled at rising edge N, and the corresponding `out`/`valid` are visible after edge N and held until edge N+1.
- Throughput is one new vector per clock. Back-to-back changes are each reflected on the next edge with no hazards or skipped vectors.
- `out` and `valid` come from the same register stage, so they are always consistent with the same sampled `in`.
- Asserting `rst_n` low:
  - Immediately forces `out` = 0 and `valid` = 0, independent of `clk`.
  - This holds even in mid-operation.
- Deasserting `rst_n`:
  - The first valid result appears after the first rising edge at which `rst_n` is high.
  - The value of `in` during reset has no lasting effect.
- `in` must meet setup/hold to `clk`. The block does not synchronize asynchronous requests.

## Test plan

Apply a vector before the edge, then check `out`/`valid` after that edge:

- Reset: hold `rst_n`=0 with `in`=8'b1111_1111 → `out`=000, `valid`=0 throughout, including mid-cycle assertion after a nonzero result.
- Empty input: `in`=8'b0000_0000 → `out`=000, `valid`=0.
- Single hot bits, sweeping i = 0..7:
  - `in`=1<<i → `out`=i, `valid`=1.
  - Example: 8'b0000_0001 → 000/1.
  - Example: 8'b1000_0000 → 111/1.
- Multiple bits set, MSB priority:
  - 8'b0101_0000 → 110/1.
  - 8'b0000_1111 → 011/1.
  - 8'b1111_1111 → 111/1.
  - 8'b0010_0110 → 101/1.
- Back-to-back vectors over consecutive cycles, 8'b0000_0100 → 8'b0000_0000 → 8'b0100_0001 → `out`/`valid` sequence 010/1, 000/0, 110/1, each appearing exactly one edge after the matching input.
- Reset mid-stream: drop `rst_n` between two nonzero vectors, then release → outputs clear asynchronously, and the first post-release edge reflects the current `in` only.

Source files
------------

// File: rtl/priority_encoder.sv
// Registered IN_W-to-OUT_W priority encoder: the highest-numbered set request bit
// becomes a binary index one clock later. A companion valid flag marks a non-empty request.
module priority_encoder #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [OUT_W-1:0] w_idx;
    logic             w_any;
    logic [OUT_W-1:0] r_out;
    logic             r_valid;

    // Ascending scan: a later (higher) set bit overwrites earlier ones, so the MSB wins.
    // Only indices below IN_W are ever produced, so unused codes cannot appear.
    always_comb begin
        w_idx = '0;
        w_any = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (in[i]) begin
                w_idx = OUT_W'(i);
                w_any = 1'b1;
            end
        end
    end

    // No handshake: a new vector is sampled every clock, with no enable or backpressure.
    // out and valid share one register stage, so both always describe the same sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_idx;
            r_valid <= w_any;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed bench for priority_encoder: literal per-vector expectations plus a
// floor(log2) reference model that is compared against the DUT on every falling edge.
module tb_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;

    int checks;
    int errors;

    logic [2:0] m_out;
    logic       m_valid;
    logic       cmp_en;

    priority_encoder #(.IN_W(8), .OUT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out),
        .valid (valid)
    );

    // Clock: 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference index = floor(log2(v)), computed by repeated halving.
    function automatic logic [2:0] ref_index(input logic [7:0] v);
        int n;
        int idx;
        n   = int'(v);
        idx = 0;
        while (n > 1) begin
            n   = n / 2;
            idx = idx + 1;
        end
        return 3'(idx);
    endfunction

    // Model of the register stage: takes in at each rising edge, clears when reset is low.
    initial begin
        m_out   = 3'd0;
        m_valid = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   = 3'd0;
            m_valid = 1'b0;
        end else begin
            m_out   = ref_index(in);
            m_valid = (in != 8'd0);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out", {5'd0, out}, {5'd0, m_out});
            check("model_valid", {7'd0, valid}, {7'd0, m_valid});
        end
    end

    // Drive a vector before the edge, then check the literal expectation just after it.
    task automatic apply(input logic [7:0] vec, input logic [2:0] eo, input logic ev);
        @(negedge clk);
        in = vec;
        @(posedge clk);
        #1;
        check($sformatf("vec_%02h_out", vec), {5'd0, out}, {5'd0, eo});
        check($sformatf("vec_%02h_valid", vec), {7'd0, valid}, {7'd0, ev});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        in     = 8'hFF;

        // Reset held with all requests active
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold_out", {5'd0, out}, 8'd0);
            check("reset_hold_valid", {7'd0, valid}, 8'd0);
        end
        cmp_en = 1'b1;
        @(negedge clk);
        in    = 8'h00;
        rst_n = 1'b1;

        // Empty input
        apply(8'h00, 3'd0, 1'b0);

        // Single hot sweep
        for (int i = 0; i < 8; i++) begin
            apply(8'(1 << i), 3'(i), 1'b1);
        end

        // Multiple bits set: MSB wins
        apply(8'b0101_0000, 3'b110, 1'b1);
        apply(8'b0000_1111, 3'b011, 1'b1);
        apply(8'b1111_1111, 3'b111, 1'b1);
        apply(8'b0010_0110, 3'b101, 1'b1);

        // Back-to-back vectors on consecutive cycles
        apply(8'b0000_0100, 3'b010, 1'b1);
        apply(8'b0000_0000, 3'b000, 1'b0);
        apply(8'b0100_0001, 3'b110, 1'b1);

        // Reset mid-stream: asynchronous clear between two nonzero vectors
        apply(8'b1001_0000, 3'b111, 1'b1);
        @(negedge clk);
        in = 8'b0000_0011;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_out", {5'd0, out}, 8'd0);
        check("async_clear_valid", {7'd0, valid}, 8'd0);
        @(posedge clk);
        #1;
        check("reset_mid_out", {5'd0, out}, 8'd0);
        check("reset_mid_valid", {7'd0, valid}, 8'd0);
        @(negedge clk);
        in    = 8'b0010_0010;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release_out", {5'd0, out}, {5'd0, 3'b101});
        check("post_release_valid", {7'd0, valid}, 8'd1);

        apply(8'b0000_0001, 3'b000, 1'b1);
        apply(8'b1000_0000, 3'b111, 1'b1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
